// File: rtl/namco_io56xx_ctrl.sv
// Two Namco custom I/O chips in the $4800-$4FFF window: 2x16 nibble registers
// refreshed once per frame on VBLANK from the sticks, buttons, coins and DIP switches.
module namco_io56xx_ctrl #(
    parameter logic [7:0] MAXCRED         = 8'h99,
    parameter logic [3:0] UPD_MODE_CREDIT = 4'h1,
    parameter logic [3:0] UPD_MODE_SWITCH = 4'h3
) (
    input  logic        MCPU_CLK,
    input  logic        RESET,
    input  logic        VBLANK,
    input  logic        CS,
    input  logic        WE,
    input  logic [5:0]  ADRS,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    input  logic [11:0] INP,
    input  logic [2:0]  INP2,
    input  logic [23:0] DSW,
    output logic [2:0]  dbg_state   // 0 IDLE, 1 LATCH, 2 CREDIT, 3 WRITE, 4 DONE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_CREDIT = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  ram [0:31];
    logic [3:0]  idx;
    logic [7:0]  credits, cr_add, cr_next;
    logic [3:0]  mode;
    logic [11:0] snap_inp;
    logic [2:0]  snap_inp2;
    logic [23:0] snap_dsw, dsw_sh;
    logic [6:0]  cur_bits, prev_bits, rise;
    logic        vb_s1, vb_s2, vb_d, vb_edge;
    logic        cpu_we, fsm_we;
    logic [4:0]  fsm_addr;
    logic [3:0]  fsm_data;
    logic        unused_ok;

    assign cpu_we    = CS & WE;
    assign vb_edge   = vb_s2 & ~vb_d;
    assign dbg_state = state;
    assign DO        = CS ? {4'h0, ram[ADRS[4:0]]} : 8'h00;
    assign unused_ok = ^{ADRS[5], DI[7:4]};

    // {2P B2, 2P B1, 1P B2, 1P B1, Coin, Start2, Start1}
    assign cur_bits = {INP[11], INP[10], INP[5], INP[4], INP2};

    always_ff @(posedge MCPU_CLK or posedge RESET) begin
        if (RESET) begin
            vb_s1 <= 1'b0;
            vb_s2 <= 1'b0;
            vb_d  <= 1'b0;
        end else begin
            vb_s1 <= VBLANK;
            vb_s2 <= vb_s1;
            vb_d  <= vb_s2;
        end
    end

    always_ff @(posedge MCPU_CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            idx       <= 4'd0;
            mode      <= 4'd0;
            snap_inp  <= 12'd0;
            snap_inp2 <= 3'd0;
            snap_dsw  <= 24'd0;
            prev_bits <= 7'd0;
            rise      <= 7'd0;
        end else begin
            state <= state_nxt;
            if (state == S_LATCH) begin
                snap_inp  <= INP;
                snap_inp2 <= INP2;
                snap_dsw  <= DSW;
                mode      <= ram[8];
                rise      <= cur_bits & ~prev_bits;
                prev_bits <= cur_bits;
            end
            if (state == S_CREDIT)
                idx <= 4'd0;
            else if (state == S_WRITE)
                idx <= idx + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (vb_edge) state_nxt = S_LATCH;
            S_LATCH:  state_nxt = S_CREDIT;
            S_CREDIT: state_nxt = S_WRITE;
            S_WRITE:  if (idx == 4'd13) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // BCD credit update: coin add (saturating) first, then Start1 over Start2.
    always_comb begin
        cr_add  = credits;
        cr_next = credits;
        if (rise[2] && credits != MAXCRED)
            cr_add = (credits[3:0] == 4'd9) ? {credits[7:4] + 4'd1, 4'd0}
                                            : {credits[7:4], credits[3:0] + 4'd1};
        cr_next = cr_add;
        if (rise[0] && cr_add != 8'h00)
            cr_next = (cr_add[3:0] == 4'd0) ? {cr_add[7:4] - 4'd1, 4'd9}
                                            : {cr_add[7:4], cr_add[3:0] - 4'd1};
        else if (rise[1] && cr_add >= 8'h02)
            cr_next = (cr_add[3:0] >= 4'd2) ? {cr_add[7:4], cr_add[3:0] - 4'd2}
                                            : {cr_add[7:4] - 4'd1, cr_add[3:0] + 4'd8};
    end

    always_ff @(posedge MCPU_CLK or posedge RESET) begin
        if (RESET) begin
            credits <= 8'h00;
        end else begin
            if (state == S_CREDIT && mode == UPD_MODE_CREDIT)
                credits <= cr_next;
            if (cpu_we && ADRS[4:0] == 5'd2)
                credits[7:4] <= DI[3:0];
            if (cpu_we && ADRS[4:0] == 5'd3)
                credits[3:0] <= DI[3:0];
        end
    end

    assign dsw_sh = snap_dsw >> {idx[2:0], 2'b00};

    always_comb begin
        fsm_we   = 1'b0;
        fsm_addr = 5'd0;
        fsm_data = 4'd0;
        if (state == S_WRITE) begin
            if (idx[3]) begin
                fsm_we   = 1'b1;
                fsm_addr = {2'b10, idx[2:0]};
                fsm_data = dsw_sh[3:0];
            end else begin
                fsm_addr = {2'b00, idx[2:0]};
                if (mode == UPD_MODE_CREDIT)
                    fsm_we = 1'b1;
                else if (mode == UPD_MODE_SWITCH)
                    fsm_we = (idx[2:0] == 3'd0) || idx[2];
                case (idx[2:0])
                    3'd0:    fsm_data = (mode == UPD_MODE_SWITCH) ? {1'b0, snap_inp2} : 4'h0;
                    3'd1:    fsm_data = 4'h0;
                    3'd2:    fsm_data = credits[7:4];
                    3'd3:    fsm_data = credits[3:0];
                    3'd4:    fsm_data = snap_inp[3:0];
                    3'd5:    fsm_data = {rise[4], snap_inp[5], rise[3], snap_inp[4]};
                    3'd6:    fsm_data = snap_inp[9:6];
                    default: fsm_data = {rise[6], snap_inp[11], rise[5], snap_inp[10]};
                endcase
            end
        end
    end

    // CPU write is applied last so it wins over a same-cycle sequencer write.
    always_ff @(posedge MCPU_CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++)
                ram[i] <= 4'd0;
        end else begin
            if (fsm_we)
                ram[fsm_addr] <= fsm_data;
            if (cpu_we)
                ram[ADRS[4:0]] <= DI[3:0];
        end
    end

endmodule

// File: tb/tb_namco_io56xx_ctrl.sv
// Self-checking bench for namco_io56xx_ctrl: directed frames plus randomized
// frames compared against a register/credit model built from the frame rules.
module tb_namco_io56xx_ctrl;

  logic        MCPU_CLK = 1'b0;
  logic        RESET;
  logic        VBLANK;
  logic        CS;
  logic        WE;
  logic [5:0]  ADRS;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic [11:0] INP;
  logic [2:0]  INP2;
  logic [23:0] DSW;
  logic [2:0]  dbg_state;

  localparam logic [2:0] ST_IDLE = 3'd0;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  int m_ram [32];
  int m_cred;
  bit p_coin, p_st1, p_st2, p_b1a, p_b2a, p_b1b, p_b2b;

  namco_io56xx_ctrl dut (
    .MCPU_CLK  (MCPU_CLK),
    .RESET     (RESET),
    .VBLANK    (VBLANK),
    .CS        (CS),
    .WE        (WE),
    .ADRS      (ADRS),
    .DI        (DI),
    .DO        (DO),
    .INP       (INP),
    .INP2      (INP2),
    .DSW       (DSW),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 MCPU_CLK = ~MCPU_CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 0;
    m_cred = 0;
    {p_coin, p_st1, p_st2, p_b1a, p_b2a, p_b1b, p_b2b} = '0;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [3:0] d);
    m_ram[a[4:0]] = int'(d);
    if (a[4:0] == 5'd2) m_cred = int'(d) * 10 + m_cred % 10;
    if (a[4:0] == 5'd3) m_cred = (m_cred / 10) * 10 + int'(d);
  endtask

  task automatic model_frame(input logic [11:0] inp, input logic [2:0] inp2, input logic [23:0] dsw);
    bit coin, st2, st1, b1a, b2a, b1b, b2b;
    bit r_coin, r_st1, r_st2, r_b1a, r_b2a, r_b1b, r_b2b;
    int mode;
    coin = inp2[2]; st2 = inp2[1]; st1 = inp2[0];
    b1a = inp[4]; b2a = inp[5]; b1b = inp[10]; b2b = inp[11];
    r_coin = coin & !p_coin; r_st1 = st1 & !p_st1; r_st2 = st2 & !p_st2;
    r_b1a = b1a & !p_b1a; r_b2a = b2a & !p_b2a; r_b1b = b1b & !p_b1b; r_b2b = b2b & !p_b2b;
    mode = m_ram[8];
    if (mode == 1) begin
      if (r_coin && m_cred < 99) m_cred = m_cred + 1;
      if (r_st1 && m_cred >= 1) m_cred = m_cred - 1;
      else if (r_st2 && m_cred >= 2) m_cred = m_cred - 2;
      m_ram[0] = 0;
      m_ram[1] = 0;
      m_ram[2] = m_cred / 10;
      m_ram[3] = m_cred % 10;
    end
    if (mode == 3)
      m_ram[0] = int'(coin) * 4 + int'(st2) * 2 + int'(st1);
    if (mode == 1 || mode == 3) begin
      m_ram[4] = int'(inp[3:0]);
      m_ram[5] = int'(r_b2a) * 8 + int'(b2a) * 4 + int'(r_b1a) * 2 + int'(b1a);
      m_ram[6] = int'(inp[9:6]);
      m_ram[7] = int'(r_b2b) * 8 + int'(b2b) * 4 + int'(r_b1b) * 2 + int'(b1b);
    end
    for (int k = 0; k < 6; k++)
      m_ram[16 + k] = int'((dsw >> (4 * k)) & 24'hF);
    {p_coin, p_st1, p_st2, p_b1a, p_b2a, p_b1b, p_b2b} = {coin, st1, st2, b1a, b2a, b1b, b2b};
  endtask

  // driver tasks
  task automatic cpu_write(input logic [5:0] a, input logic [3:0] d);
    @(posedge MCPU_CLK); #1;
    CS = 1'b1; WE = 1'b1; ADRS = a; DI = {4'($urandom_range(0, 15)), d};
    @(posedge MCPU_CLK); #1;
    CS = 1'b0; WE = 1'b0;
    model_write(a, d);
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [7:0] d);
    CS = 1'b1; WE = 1'b0; ADRS = a;
    #1 d = DO;
    CS = 1'b0;
  endtask

  task automatic run_frame(input logic [11:0] inp, input logic [2:0] inp2, input logic [23:0] dsw);
    @(posedge MCPU_CLK); #1;
    INP = inp; INP2 = inp2; DSW = dsw;
    VBLANK = 1'b1;
    repeat (22) @(posedge MCPU_CLK);
    #1 VBLANK = 1'b0;
    repeat (3) @(posedge MCPU_CLK);
    #1;
    model_frame(inp, inp2, dsw);
    check_eq("idle_after_frame", {5'd0, dbg_state}, {5'd0, ST_IDLE});
  endtask

  task automatic check_reg(input string tag, input logic [5:0] a, input logic [3:0] exp);
    logic [7:0] d;
    cpu_read(a, d);
    check_eq(tag, d, {4'h0, exp});
  endtask

  task automatic check_all(input string tag);
    logic [7:0] d;
    logic [5:0] a;
    for (int i = 0; i < 32; i++) begin
      cpu_read(6'(i), d);
      check_eq($sformatf("%s[%02h]", tag, i), d, 8'(m_ram[i]));
    end
    a = 6'($urandom_range(32, 63));
    cpu_read(a, d);
    check_eq($sformatf("%s_mirror[%02h]", tag, a), d, 8'(m_ram[a[4:0]]));
  endtask

  initial begin
    logic [7:0] d;
    RESET = 1'b1; VBLANK = 1'b0; CS = 1'b0; WE = 1'b0;
    ADRS = '0; DI = '0; INP = '0; INP2 = '0; DSW = '0;
    model_reset();
    repeat (3) @(posedge MCPU_CLK);
    #1 RESET = 1'b0;
    @(posedge MCPU_CLK); #1;

    // reset state over the full mirrored window
    check_eq("reset_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
    for (int i = 0; i < 64; i++) begin
      cpu_read(6'(i), d);
      check_eq($sformatf("reset_rd[%02h]", i), d, 8'h00);
    end
    cpu_write(6'h05, 4'h7);
    check_reg("mirror_25", 6'h25, 4'h7);
    ADRS = 6'h05; CS = 1'b0;
    #1 check_eq("cs_low_do", DO, 8'h00);

    // credit mode: three coins
    cpu_write(6'h08, 4'h1);
    for (int i = 0; i < 3; i++) begin
      run_frame(12'h000, 3'b100, 24'h0);
      run_frame(12'h000, 3'b000, 24'h0);
    end
    check_reg("coin3_r2", 6'h02, 4'h0);
    check_reg("coin3_r3", 6'h03, 4'h3);
    check_all("coin3");

    // saturation at 99
    cpu_write(6'h02, 4'h9);
    cpu_write(6'h03, 4'h9);
    run_frame(12'h000, 3'b100, 24'h0);
    check_reg("sat_r2", 6'h02, 4'h9);
    check_reg("sat_r3", 6'h03, 4'h9);
    run_frame(12'h000, 3'b000, 24'h0);

    // Start2 with 10 credits borrows across the digit
    cpu_write(6'h02, 4'h1);
    cpu_write(6'h03, 4'h0);
    run_frame(12'h000, 3'b010, 24'h0);
    check_reg("st2_10_r2", 6'h02, 4'h0);
    check_reg("st2_10_r3", 6'h03, 4'h8);
    run_frame(12'h000, 3'b000, 24'h0);

    // Start2 with only 1 credit does nothing
    cpu_write(6'h03, 4'h1);
    run_frame(12'h000, 3'b010, 24'h0);
    check_reg("st2_1_r2", 6'h02, 4'h0);
    check_reg("st2_1_r3", 6'h03, 4'h1);
    run_frame(12'h000, 3'b000, 24'h0);

    // coin and Start1 together from zero: add then subtract
    cpu_write(6'h03, 4'h0);
    run_frame(12'h000, 3'b101, 24'h0);
    check_reg("coin_st1_r2", 6'h02, 4'h0);
    check_reg("coin_st1_r3", 6'h03, 4'h0);
    run_frame(12'h000, 3'b000, 24'h0);
    check_all("credit_dir");

    // switch mode
    cpu_write(6'h08, 4'h3);
    cpu_write(6'h03, 4'h4);
    run_frame(12'h000, 3'b101, 24'h0);
    check_reg("sw_r0", 6'h00, 4'h5);
    check_reg("sw_r2", 6'h02, 4'h0);
    check_reg("sw_r3", 6'h03, 4'h4);
    run_frame(12'h010, 3'b000, 24'h0);
    check_reg("b1_hold_f1", 6'h05, 4'h3);
    run_frame(12'h010, 3'b000, 24'h0);
    check_reg("b1_hold_f2", 6'h05, 4'h1);
    check_all("switch_dir");

    // DIP switches visible 17 cycles after the synchronised edge
    @(posedge MCPU_CLK); #1;
    INP = 12'h000; INP2 = 3'b000; DSW = 24'hA5C3F0;
    VBLANK = 1'b1;
    repeat (19) @(posedge MCPU_CLK);
    #1;
    check_reg("dsw_10", 6'h10, 4'h0);
    check_reg("dsw_11", 6'h11, 4'hF);
    check_reg("dsw_12", 6'h12, 4'h3);
    check_reg("dsw_13", 6'h13, 4'hC);
    check_reg("dsw_14", 6'h14, 4'h5);
    check_reg("dsw_15", 6'h15, 4'hA);
    repeat (3) @(posedge MCPU_CLK);
    #1 VBLANK = 1'b0;
    repeat (3) @(posedge MCPU_CLK);
    #1 model_frame(12'h000, 3'b000, 24'hA5C3F0);
    check_all("dsw");

    // reset in the middle of the WRITE phase (index 5)
    @(posedge MCPU_CLK); #1;
    INP = 12'hFFF; INP2 = 3'b111; DSW = 24'h123456;
    VBLANK = 1'b1;
    repeat (10) @(posedge MCPU_CLK);
    #1 RESET = 1'b1;
    VBLANK = 1'b0;
    repeat (3) @(posedge MCPU_CLK);
    #1 RESET = 1'b0;
    model_reset();
    repeat (25) @(posedge MCPU_CLK);
    #1;
    check_eq("abort_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
    check_all("abort");

    // CPU write on the sequencer's r4 cycle wins
    cpu_write(6'h08, 4'h1);
    @(posedge MCPU_CLK); #1;
    INP = 12'h00A; INP2 = 3'b000; DSW = 24'h0F0F0F;
    VBLANK = 1'b1;
    repeat (9) @(posedge MCPU_CLK);
    #1 CS = 1'b1; WE = 1'b1; ADRS = 6'h04; DI = 8'h05;
    @(posedge MCPU_CLK);
    #1 CS = 1'b0; WE = 1'b0;
    repeat (12) @(posedge MCPU_CLK);
    #1 VBLANK = 1'b0;
    repeat (3) @(posedge MCPU_CLK);
    #1;
    model_frame(12'h00A, 3'b000, 24'h0F0F0F);
    model_write(6'h04, 4'h5);
    check_reg("collide_r4", 6'h04, 4'h5);
    check_all("collide");

    // randomized frames
    for (int it = 0; it < 150; it++) begin
      int nw;
      logic [5:0] a;
      logic [3:0] v;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        a = 6'($urandom_range(0, 63));
        v = 4'($urandom_range(0, 15));
        if (a[4:0] == 5'd2 || a[4:0] == 5'd3) v = 4'($urandom_range(0, 9));
        if (a[4:0] == 5'd8) v = 4'h1;
        cpu_write(a, v);
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: v = 4'h1;
          1: v = 4'h3;
          2: v = 4'h0;
          default: v = 4'($urandom_range(0, 15));
        endcase
        cpu_write(6'h08, v);
      end
      run_frame(12'($urandom), 3'($urandom), 24'($urandom));
      check_all($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
